// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES datapath constants, FSM state type and parameter check
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int c_STATE_W   = 128;
    localparam int c_NUM_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_t;

    // Group size must divide the 16-byte state evenly.
    function automatic bit bpc_is_legal(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_s_box.sv
// ============================================================================
// Module : inv_s_box
// Brief  : Combinational AES inverse S-box, 8-bit in / 8-bit out lookup
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inv_s_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 sits in the most significant byte of the first row.
    localparam logic [0:255][7:0] c_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = c_INV_SBOX[in_byte];

endmodule

`default_nettype wire

// File: rtl/inv_sub_bytes.sv
// ============================================================================
// Module : inv_sub_bytes
// Brief  : Iterative AES InvSubBytes, BYTES_PER_CYCLE bytes substituted per clock
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [c_STATE_W-1:0] in_state,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [c_STATE_W-1:0] out_state,
    output logic                 busy
);

    if (!bpc_is_legal(BYTES_PER_CYCLE)) begin : g_bpc_check
        $error("inv_sub_bytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int c_NUM_GRPS = c_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int c_GRP_W    = (c_NUM_GRPS > 1) ? $clog2(c_NUM_GRPS) : 1;

    sub_state_t                     r_state;
    sub_state_t                     w_state_nxt;
    logic [c_GRP_W-1:0]             r_grp;
    // Byte 0 occupies the top of the packed vector, matching FIPS-197 order.
    logic [0:c_NUM_BYTES-1][7:0]    r_data;
    logic                           w_last_grp;
    logic [3:0]                     w_base;
    logic [3:0]                     w_idx [BYTES_PER_CYCLE];
    logic [7:0]                     w_sel [BYTES_PER_CYCLE];
    logic [7:0]                     w_sub [BYTES_PER_CYCLE];

    assign w_last_grp = (r_grp == c_GRP_W'(c_NUM_GRPS - 1));
    assign w_base     = 4'(32'(r_grp) * BYTES_PER_CYCLE);

    for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
        assign w_idx[k] = w_base + 4'(k);
        assign w_sel[k] = r_data[w_idx[k]];

        inv_s_box u_inv_s_box (
            .in_byte  (w_sel[k]),
            .out_byte (w_sub[k])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)   w_state_nxt = ST_SUB;
            ST_SUB:  if (w_last_grp) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)  w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grp   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data <= in_state;
                        r_grp  <= '0;
                    end
                end
                ST_SUB: begin
                    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
                        r_data[w_idx[k]] <= w_sub[k];
                    end
                    r_grp <= w_last_grp ? '0 : r_grp + c_GRP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_SUB);
    assign out_valid = (r_state == ST_DONE);
    assign out_state = r_data;

endmodule

`default_nettype wire

// File: tb/tb_inv_sub_bytes.sv
// ============================================================================
// Module : tb_inv_sub_bytes
// Brief  : Scoreboard bench for inv_sub_bytes against a GF(2^8)-derived model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inv_sub_bytes;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] out_state;

    logic         sw_valid1, sw_valid16, sw_ready;
    logic [127:0] sw_state;
    logic         sw1_in_ready, sw1_out_valid, sw1_busy;
    logic         sw16_in_ready, sw16_out_valid, sw16_busy;
    logic [127:0] sw1_out_state, sw16_out_state;

    int           n_checks = 0;
    int           n_fail   = 0;
    bit           mon_en   = 1'b0;
    logic [127:0] exp_q [$];
    logic [7:0]   fwd_tbl [256];
    logic [7:0]   inv_tbl [256];

    always #5 clk = ~clk;

    inv_sub_bytes u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy)
    );

    inv_sub_bytes #(.BYTES_PER_CYCLE(1)) u_dut_bpc1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid1), .in_ready(sw1_in_ready),
        .in_state(sw_state), .out_valid(sw1_out_valid), .out_ready(sw_ready),
        .out_state(sw1_out_state), .busy(sw1_busy)
    );

    inv_sub_bytes #(.BYTES_PER_CYCLE(16)) u_dut_bpc16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid16), .in_ready(sw16_in_ready),
        .in_state(sw_state), .out_valid(sw16_out_valid), .out_ready(sw_ready),
        .out_state(sw16_out_state), .busy(sw16_busy)
    );

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Reference model: S-box from field inverse plus affine map, then inverted.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic void build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            fwd_tbl[x] = s;
            inv_tbl[s] = 8'(x);
        end
    endfunction

    function automatic logic [127:0] model_inv(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv_tbl[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every cycle in DONE must present the queued result.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("one_hot_status", 128'($countones({in_ready, busy, out_valid})), 128'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, expected no output", out_state);
                end else begin
                    check("out_state", out_state, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_timeout", 128'(in_ready), 128'd1);
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] exp, input int bp);
        int lat = 0;
        wait_ready();
        in_state  = d;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = (bp > 0);
        in_state = rnd128();
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 128'(lat), 128'd4);
        if (bp > 0) begin
            for (int c = 0; c < bp; c++) begin
                in_valid = c[0];
                in_state = rnd128();
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check("in_ready_after_out_hs", 128'(in_ready), 128'd1);
            check("out_valid_after_out_hs", 128'(out_valid), 128'd0);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sweep(input bit big, input int exp_lat);
        int lat = 0;
        check("sweep_ready", 128'(big ? sw16_in_ready : sw1_in_ready), 128'd1);
        sw_state = {16{8'h63}};
        if (big) sw_valid16 = 1'b1; else sw_valid1 = 1'b1;
        @(posedge clk);
        #1;
        sw_valid1  = 1'b0;
        sw_valid16 = 1'b0;
        while (!(big ? sw16_out_valid : sw1_out_valid) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(big ? "sweep16_latency" : "sweep1_latency", 128'(lat), 128'(exp_lat));
        check(big ? "sweep16_result" : "sweep1_result",
              big ? sw16_out_state : sw1_out_state, 128'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] d, e;
        build_tables();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_state   = '0;
        sw_valid1  = 1'b0;
        sw_valid16 = 1'b0;
        sw_ready   = 1'b1;
        sw_state   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_state", out_state, 128'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        send({16{8'h63}}, 128'h0, 0);
        send(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, 0);
        send(128'h0016_0000_0000_0000_0000_0000_0000_0000,
             128'h52ff_5252_5252_5252_5252_5252_5252_5252, 0);
        d = 128'h52096ad53036a538bf40a39e81f3d7fb;
        send(d, model_inv(d), 0);

        for (int j = 0; j < 256; j++) begin
            for (int i = 0; i < 16; i++) begin
                e[127-8*i -: 8] = 8'((j + i) & 255);
                d[127-8*i -: 8] = fwd_tbl[(j + i) & 255];
            end
            send(d, e, 0);
        end

        for (int r = 0; r < 40; r++) begin
            d = rnd128();
            send(d, model_inv(d), (r % 4 == 0) ? 10 : 0);
        end

        // Reset two edges into SUB must abandon the result.
        wait_ready();
        in_state = rnd128();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_out_state", out_state, 128'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'd1);

        d = rnd128();
        send(d, model_inv(d), 0);

        sweep(1'b0, 16);
        sweep(1'b1, 1);

        repeat (3) @(posedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
